// File: rtl/icache_pkg.sv
// Shared widths, FSM states and address-field helpers for the direct-mapped instruction cache.
// Field widths derive from DEF_NLINES/DEF_WORDS; resize the cache here rather than by overriding top parameters.
package icache_pkg;

  localparam int DEF_NLINES = 16;
  localparam int DEF_WORDS  = 4;
  localparam int OB = $clog2(DEF_WORDS);
  localparam int IB = $clog2(DEF_NLINES);
  localparam int TB = 32 - 2 - OB - IB;

  typedef enum logic {IDLE, FILL} state_t;

  typedef struct packed {
    logic [TB-1:0] tag;
    logic [IB-1:0] index;
    logic [OB-1:0] offset;
  } fields_t;

  function automatic fields_t split_addr(input logic [31:0] addr);
    return fields_t'(addr[31:2]);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, synchronous word write and line validate.
module icache_array import icache_pkg::*; #(
  parameter int NLINES = DEF_NLINES,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [IB-1:0] rindex,
  input  logic [OB-1:0] roffset,
  output logic          line_valid,
  output logic [TB-1:0] line_tag,
  output logic [31:0]   line_word,
  input  logic          we,
  input  logic [IB-1:0] windex,
  input  logic [OB-1:0] woffset,
  input  logic [31:0]   wdata,
  input  logic          vset,
  input  logic          vbit,
  input  logic [TB-1:0] vtag
);

  logic [NLINES-1:0] valid;
  logic [TB-1:0]     tags [NLINES];
  logic [31:0]       data [NLINES][WORDS];

  assign line_valid = valid[rindex];
  assign line_tag   = tags[rindex];
  assign line_word  = data[rindex][roffset];

  // Clear-all wins over a same-edge validate so a flush on the last beat leaves the line invalid.
  always_ff @(posedge clk) begin
    if (clear)
      valid <= '0;
    else if (vset)
      valid[windex] <= vbit;
  end

  always_ff @(posedge clk) begin
    if (vset)
      tags[windex] <= vtag;
    if (we)
      data[windex][woffset] <= wdata;
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, stalling line refill from memory.
module icache_dm import icache_pkg::*; #(
  parameter int NLINES = DEF_NLINES,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  state_t        state;
  logic [OB-1:0] beat;
  logic          abort;
  logic [IB-1:0] fill_index;
  logic [TB-1:0] fill_tag;

  fields_t       f;
  logic          line_valid;
  logic [TB-1:0] line_tag;
  logic [31:0]   line_word;
  logic          hit;
  logic          fill_we;
  logic          last_beat;

  assign f         = split_addr(pc);
  assign hit       = (state == IDLE) && line_valid && (line_tag == f.tag);
  assign stall     = ~reset & ~hit;
  assign instr     = (hit && !reset) ? line_word : 32'h0;
  assign fill_we   = (state == FILL) && mem_req && mem_rvalid && !reset;
  assign last_beat = (beat == OB'(WORDS - 1));

  icache_array #(.NLINES(NLINES), .WORDS(WORDS)) u_array (
    .clk        (clk),
    .clear      (reset | flush),
    .rindex     (f.index),
    .roffset    (f.offset),
    .line_valid (line_valid),
    .line_tag   (line_tag),
    .line_word  (line_word),
    .we         (fill_we),
    .windex     (fill_index),
    .woffset    (beat),
    .wdata      (mem_rdata),
    .vset       (fill_we && last_beat),
    .vbit       (~abort),
    .vtag       (fill_tag)
  );

  // A flush mid-fill cannot cancel the outstanding beats, so it marks the line to be dropped on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      beat     <= '0;
      abort    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            fill_index <= f.index;
            fill_tag   <= f.tag;
            beat       <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= {f.tag, f.index, {OB{1'b0}}, 2'b00};
            state      <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            if (last_beat) begin
              mem_req <= 1'b0;
              abort   <= 1'b0;
              state   <= IDLE;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= mem_addr + 32'd4;
              if (flush)
                abort <= 1'b1;
            end
          end else if (flush) begin
            abort <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache. It sits directly upstream of the single-cycle MIPS datapath and supplies `instr` for the current `pc`.
- On a hit, `instr` is returned combinationally in the same cycle.
- On a miss, it stalls the core and refills one line from main memory over a single-outstanding req/rvalid handshake.
- The core holds `pc` and all architectural state while `stall` is high.

Parameters:
- NLINES, 16, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  fetch address from the PC register; bits [1:0] ignored
- instr  out  32  instruction for `pc`; valid when stall=0
- stall  out  1  high means the core must not advance pc or commit any write
- flush  in  1  one-cycle pulse that invalidates all lines
- mem_req  out  1  read request to main memory (registered)
- mem_addr  out  32  word-aligned address of the current beat (registered)
- mem_rdata  in  32  read data
- mem_rvalid  in  1  mem_rdata is valid for mem_addr this cycle

Behaviour:
- Address split (defaults):
  - offset = pc[3:2], i.e. pc[2+OB-1:2], with OB = log2(WORDS)
  - index = pc[7:4], with IB = log2(NLINES)
  - tag = pc[31:8], i.e. remaining upper bits
- Storage: valid[NLINES], tag[NLINES], data[NLINES][WORDS].
  - Reset clears all valid bits.
  - Tag and data arrays are not reset.
- hit = state==IDLE & valid[index] & tag[index]==pc tag.
- instr = data[index][offset] when hit, else 32'h0 (NOP).
- stall = ~hit while reset=0. stall=0 while reset=1.
- FSM states: IDLE, FILL.
  - IDLE, no hit, reset=0: latch fill_index and fill_tag from pc; beat:=0; go to FILL.
    - mem_req=1 and mem_addr={pc tag, pc index, OB'b0, 2'b00} are registered at this edge.
  - FILL, mem_rvalid=0: hold mem_req, mem_addr and beat unchanged. There is no timeout.
  - FILL, mem_rvalid=1, beat<WORDS-1: write data[fill_index][beat]:=mem_rdata; beat+1; mem_addr+4.
  - FILL, mem_rvalid=1, beat==WORDS-1: write the last word; tag[fill_index]:=fill_tag; valid[fill_index]:=~abort; mem_req:=0; abort:=0; go to IDLE.
  - mem_rvalid is ignored while mem_req=0.
- Fill order and wrap:
  - Words are always fetched 0..WORDS-1. There is no critical-word-first.
  - `beat` is OB bits wide and never wraps inside a fill.
- Miss penalty with zero-wait memory (rvalid in every FILL cycle):
  - stall is high for WORDS+1 cycles: the detect cycle plus WORDS beats.
  - The hit is seen the cycle after the last beat.
- Flush:
  - flush=1 in any state clears all valid bits at the edge. It takes priority over a simultaneous last-beat valid set.
  - flush during FILL, on a non-final beat or with no rvalid, sets `abort`. The fill completes all beats, leaves the line invalid, and then re-misses.
  - flush in IDLE during a hit cycle: that cycle's instr is still delivered (stall=0). The next cycle misses.
- Reset mid-fill: at the edge, state:=IDLE, mem_req:=0, mem_addr:=0, beat:=0, abort:=0, all valid:=0. A stale rvalid afterwards is ignored.
- Output reset values: mem_req=0, mem_addr=32'h0, stall=0, instr=32'h0.
- pc changes during FILL are a core protocol violation. The fill uses the latched fill_index and fill_tag regardless.

Decomposition:
- Shared package `icache_pkg`:
  - derived widths OB, IB, TB=32-2-OB-IB
  - state enum {IDLE, FILL}
  - a fields struct {tag, index, offset}
  - a function splitting a 32-bit address into that struct
- Sub-module `icache_array`:
  - valid, tag and data storage
  - asynchronous read port on index
  - synchronous word-write and line-validate ports
  - clear-all port driven by reset|flush
- Top level holds the FSM, beat counter, abort flag and memory interface.

Test Plan:
1. Cold miss: reset, then pc=0x00000000; memory returns rdata=addr with rvalid every cycle → stall=1 for 5 cycles; mem_addr 0x0,0x4,0x8,0xC on consecutive cycles; then instr=0x00000000, stall=0.
2. Line hits: after test 1, pc=0x4, 0x8, 0xC on successive cycles → stall=0 each cycle; instr=0x4, 0x8, 0xC; mem_req stays 0.
3. Conflict: pc=0x100 (index 0, tag 1) → refill from 0x100..0x10C with instr=0x100. Then pc=0x0 → misses again and refills.
4. Wait states: rvalid asserted only every 4th cycle, pc=0x40 → mem_addr is held for 4 cycles per beat; stall high for 1+16 cycles; instr=0x40.
5. Flush mid-fill: flush pulse during beat 1 of a fill for pc=0x80 → line left invalid; a second 4-beat fill follows; stall high for 10 cycles total; then instr=0x80.
6. Reset mid-fill: reset asserted at beat 2 → next cycle mem_req=0, mem_addr=0; a stray rvalid is ignored; pc=0x0 then misses (valid was cleared).
